// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and imem request issuer with an in-order instruction FIFO to decode.
// A redirect flushes the FIFO, restarts the stream and drops every response still in flight.
module fetch_queue #(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 4,
   parameter int              MAX_OUTST = 2,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0100_0000
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    imem_req_valid,
   input  logic                    imem_req_ready,
   output logic [XLEN-1:0]         imem_req_addr,
   input  logic                    imem_rsp_valid,
   input  logic [XLEN-1:0]         imem_rsp_data,
   output logic                    inst_valid,
   input  logic                    inst_ready,
   output logic [XLEN-1:0]         inst_data,
   output logic [XLEN-1:0]         inst_pc,
   input  logic                    redirect_valid,
   input  logic [XLEN-1:0]         redirect_pc,
   output logic [$clog2(DEPTH):0]  occupancy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
   localparam int PW = $clog2(MAX_OUTST + 1);
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_data  [DEPTH];
   logic [XLEN-1:0] r_tagpc [DEPTH];
   logic [XLEN-1:0] r_tag   [MAX_OUTST];
   logic [AW-1:0]   r_wr, r_rd;
   logic [TW-1:0]   r_twr, r_trd;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_pend, r_drop;
   logic            w_issue, w_push, w_pop;
   logic [31:0]     w_used;
   // credits: buffered entries plus responses that will be kept
   assign w_used         = 32'(r_count) + 32'(r_pend) - 32'(r_drop);
   assign imem_req_valid = reset && !redirect_valid && 32'(r_pend) < 32'(MAX_OUTST) && w_used < 32'(DEPTH);
   assign imem_req_addr  = r_pc;
   assign inst_valid     = r_count != '0 && !redirect_valid;
   assign inst_data      = r_data[r_rd];
   assign inst_pc        = r_tagpc[r_rd];
   assign occupancy      = r_count;
   assign w_issue        = imem_req_valid && imem_req_ready;
   assign w_push         = imem_rsp_valid && r_drop == '0 && !redirect_valid;
   assign w_pop          = inst_valid && inst_ready;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         r_pc    <= RESET_PC;
         r_wr    <= '0;
         r_rd    <= '0;
         r_twr   <= '0;
         r_trd   <= '0;
         r_count <= '0;
         r_pend  <= '0;
         r_drop  <= '0;
      end else if (redirect_valid) begin
         r_pc    <= redirect_pc & ~XLEN'(3);
         r_wr    <= '0;
         r_rd    <= '0;
         r_twr   <= '0;
         r_trd   <= '0;
         r_count <= '0;
         r_pend  <= r_pend - PW'(imem_rsp_valid);
         r_drop  <= r_pend - PW'(imem_rsp_valid);
      end else begin
         if (w_issue) r_pc <= r_pc + XLEN'(4);
         if (w_issue) r_twr <= r_twr == TW'(MAX_OUTST - 1) ? '0 : r_twr + 1'b1;
         if (w_push) r_trd <= r_trd == TW'(MAX_OUTST - 1) ? '0 : r_trd + 1'b1;
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         r_pend  <= r_pend + PW'(w_issue) - PW'(imem_rsp_valid);
         if (imem_rsp_valid && r_drop != '0) r_drop <= r_drop - 1'b1;
      end
   always_ff @(posedge clock) begin
      if (w_issue) r_tag[r_twr] <= r_pc;
      if (w_push) r_data[r_wr] <= imem_rsp_data;
      if (w_push) r_tagpc[r_wr] <= r_tag[r_trd];
   end
   a_no_push_full: assert property (@(posedge clock) disable iff (!reset) !(w_push && r_count == CW'(DEPTH) && !w_pop));
   a_pend_max:     assert property (@(posedge clock) disable iff (!reset) 32'(r_pend) <= 32'(MAX_OUTST));
   a_drop_le_pend: assert property (@(posedge clock) disable iff (!reset) r_drop <= r_pend);
   a_rsp_pending:  assert property (@(posedge clock) disable iff (!reset) !(imem_rsp_valid && r_pend == '0));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with an in-order memory model,
// epoch-tagged responses so stale ones are dropped, and directed plus random phases.
module tb_fetch_queue;
   localparam logic [31:0] RPC = 32'h0100_0000;
   typedef struct {logic [31:0] addr; int due; int ep;} req_t;
   typedef struct {logic [31:0] pc; logic [31:0] data;} ins_t;
   logic        clock = 0, reset = 0;
   logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
   logic [31:0] imem_req_addr, imem_rsp_data = 0;
   logic        inst_valid, inst_ready = 0, redirect_valid = 0;
   logic [31:0] inst_data, inst_pc, redirect_pc = 0;
   logic [2:0]  occupancy;
   req_t        mem_q[$];
   ins_t        exp_q[$];
   int          n_chk = 0, n_fail = 0, cyc = 0, epoch = 0, lat = 1;
   int          first_req_cyc = -1, first_iv_cyc = -1;
   logic        rdy = 1, req_rdy = 1, do_rdr = 0, hold_rsp = 0, rnd = 0;
   logic        saw_wrap = 0, want_pc = 0, want_req = 0;
   logic [31:0] rdr_tgt = 0, exp_addr = RPC, prev_addr = 0, first_req_addr = 0;
   fetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUTST(2), .RESET_PC(RPC)) dut (
      .clock(clock), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .occupancy(occupancy)
   );
   always #5 clock = ~clock;
   function automatic logic [31:0] mk(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   // one clock cycle: drive at negedge, observe 1ns later, before the next rising edge
   task automatic cycle();
      int   sz0, pend, kept;
      ins_t e;
      @(negedge clock);
      cyc++;
      if (rnd) begin
         rdy      = $urandom_range(0, 3) != 0;
         req_rdy  = $urandom_range(0, 3) != 0;
         hold_rsp = $urandom_range(0, 3) == 0;
         lat      = $urandom_range(1, 3);
         if ($urandom_range(0, 19) == 0) begin
            do_rdr  = 1;
            rdr_tgt = $urandom & 32'h00FF_FFFF;
         end
      end
      sz0  = exp_q.size();
      pend = mem_q.size();
      kept = 0;
      foreach (mem_q[i]) if (mem_q[i].ep == epoch) kept++;
      chk("occupancy", 32'(occupancy), 32'(sz0));
      redirect_valid = do_rdr;
      imem_rsp_valid = 0;
      if (do_rdr) begin
         redirect_pc = rdr_tgt;
         epoch++;
         exp_q.delete();
         exp_addr = rdr_tgt & ~32'h3;
         do_rdr = 0;
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && !hold_rsp) begin
         imem_rsp_valid = 1;
         imem_rsp_data  = mk(mem_q[0].addr);
         if (mem_q[0].ep == epoch) exp_q.push_back('{mem_q[0].addr, mk(mem_q[0].addr)});
         void'(mem_q.pop_front());
      end
      inst_ready     = rdy;
      imem_req_ready = req_rdy;
      #1;
      chk("req_valid", 32'(imem_req_valid), 32'(!redirect_valid && pend < 2 && sz0 + kept < 4));
      chk("inst_valid", 32'(inst_valid), 32'(sz0 > 0 && !redirect_valid));
      if (imem_req_valid && imem_req_ready) begin
         chk("req_addr", imem_req_addr, exp_addr);
         if (want_req) begin
            chk("redirect_req_addr", imem_req_addr, 32'h0100_0100);
            want_req = 0;
         end
         if (first_req_cyc < 0) begin
            first_req_cyc  = cyc;
            first_req_addr = imem_req_addr;
         end
         if (prev_addr == 32'hFFFF_FFFC && imem_req_addr == 0) saw_wrap = 1;
         prev_addr = imem_req_addr;
         exp_addr += 4;
         mem_q.push_back('{imem_req_addr, cyc + lat, epoch});
      end
      if (inst_valid && inst_ready) begin
         if (first_iv_cyc < 0) first_iv_cyc = cyc;
         chk("pop_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e.pc);
            chk("inst_data", inst_data, e.data);
            if (want_pc) begin
               chk("redirect_first_pc", inst_pc, 32'h0100_0100);
               want_pc = 0;
            end
         end
      end
   endtask
   task automatic model_reset();
      mem_q.delete();
      exp_q.delete();
      epoch++;
      exp_addr = RPC;
      prev_addr = 0;
      first_req_cyc = -1;
      imem_rsp_valid = 0;
      redirect_valid = 0;
   endtask
   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_inst_valid", 32'(inst_valid), 0);
      chk("rst_occupancy", 32'(occupancy), 0);
      reset = 1;
      repeat (20) cycle();
      chk("first_iv_latency", 32'(first_iv_cyc - first_req_cyc), 2);
      chk("first_req_addr", first_req_addr, RPC);
      rdy = 0;
      repeat (10) cycle();
      chk("stall_occupancy", 32'(occupancy), 4);
      chk("stall_req_valid", 32'(imem_req_valid), 0);
      rdy = 1;
      repeat (10) cycle();
      lat = 3;
      for (int i = 0; i < 20 && !do_rdr; i++) begin
         cycle();
         if (mem_q.size() == 2 && mem_q[0].due > cyc + 1) begin
            do_rdr  = 1;
            rdr_tgt = 32'h0100_0103;
         end
      end
      chk("redirect_setup", 32'(do_rdr), 1);
      want_pc  = 1;
      want_req = 1;
      cycle();
      lat = 1;
      repeat (15) cycle();
      chk("redirect_pc_seen", 32'(want_pc), 0);
      chk("redirect_req_seen", 32'(want_req), 0);
      rdy = 0;
      repeat (2) cycle();
      for (int i = 0; i < 10 && !do_rdr; i++) begin
         if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
            do_rdr  = 1;
            rdr_tgt = 32'h0200_0000;
         end else cycle();
      end
      chk("rdr_rsp_setup", 32'(do_rdr), 1);
      rdy = 1;
      cycle();
      chk("rdr_rsp_valid", 32'(imem_rsp_valid), 1);
      chk("rdr_inst_valid", 32'(inst_valid), 0);
      chk("rdr_nonempty", 32'(occupancy != 0), 1);
      @(posedge clock);
      #1;
      chk("rdr_occupancy", 32'(occupancy), 0);
      repeat (5) cycle();
      do_rdr  = 1;
      rdr_tgt = 32'hFFFF_FFF8;
      repeat (8) cycle();
      chk("pc_wrap", 32'(saw_wrap), 1);
      rnd = 1;
      repeat (400) cycle();
      rnd = 0;
      hold_rsp = 0;
      req_rdy = 1;
      lat = 1;
      rdy = 0;
      repeat (12) cycle();
      chk("full_occupancy", 32'(occupancy), 4);
      reset = 0;
      #1;
      chk("async_rst_occupancy", 32'(occupancy), 0);
      chk("async_rst_req_valid", 32'(imem_req_valid), 0);
      chk("async_rst_inst_valid", 32'(inst_valid), 0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1;
      rdy = 1;
      repeat (10) cycle();
      chk("restart_addr", first_req_addr, RPC);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
